// File: rtl/sdram_dump_pkg.sv
// Shared types and constants for the SDRAM-to-UART dump block.
// SDRAM_DUMP_HEX_ASCII_EN selects ASCII-hex output; see dump_byte_serializer.
package sdram_dump_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StCheck,
        StSend,
        StNext,
        StDone
    } dump_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned WORDS_PER_LINE = 8;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one SDRAM word and presents it byte by byte, MSB first.
// With SDRAM_DUMP_HEX_ASCII_EN defined, emits 4 hex chars plus a space or CR/LF separator.
module dump_byte_serializer
    import sdram_dump_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] word_i,
`ifdef SDRAM_DUMP_HEX_ASCII_EN
    input  logic        crlf_i,
`endif
    input  logic        advance_i,
    output logic [7:0]  byte_o,
    output logic        last_byte_o
);

    logic [15:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;

`ifdef SDRAM_DUMP_HEX_ASCII_EN
    logic crlf_q, crlf_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        crlf_d = crlf_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 3'd0;
            crlf_d = crlf_i;
        end else if (advance_i) begin
            word_d = {word_q[11:0], 4'h0};
            idx_d  = idx_q + 3'd1;
        end
    end

    // Indices 0-3 are hex digits, 4 is the separator, 5 is the LF of a CR/LF pair.
    always_comb begin
        byte_o = ASCII_LF;
        case (idx_q)
            3'd0, 3'd1, 3'd2, 3'd3: byte_o = nibble_to_hex(word_q[15:12]);
            3'd4:                   byte_o = crlf_q ? ASCII_CR : ASCII_SPACE;
            default:                byte_o = ASCII_LF;
        endcase
        last_byte_o = crlf_q ? (idx_q == 3'd5) : (idx_q == 3'd4);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crlf_q <= 1'b0;
        end else begin
            crlf_q <= crlf_d;
        end
    end
`else
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 3'd0;
        end else if (advance_i) begin
            word_d = {word_q[7:0], 8'h00};
            idx_d  = idx_q + 3'd1;
        end
    end

    always_comb begin
        byte_o      = word_q[15:8];
        last_byte_o = (idx_q == 3'd1);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= 16'h0000;
            idx_q  <= 3'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/sdram_uart_dump.sv
// Drains WORD_COUNT words from the SDRAM read FIFO into the UART TX FIFO as bytes.
// Build option SDRAM_DUMP_HEX_ASCII_EN switches raw binary output to ASCII hex lines.
module sdram_uart_dump
    import sdram_dump_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 512,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk_50m,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sdram_init_done,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        fifo_tx_req,
    output logic [7:0]  fifo_tx_data,
    input  logic        fifo_full,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_cnt
);

    dump_state_e state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        rd_en_q, tx_req_q, busy_q, done_q;
    logic [7:0]  tx_data_q;

    logic        ser_load, ser_advance, ser_last;
    logic [7:0]  ser_byte;

`ifdef SDRAM_DUMP_HEX_ASCII_EN
    // Word being loaded is number word_cnt_q + 1; it closes a line every 8th word or at the end.
    logic [15:0] word_num;
    logic        line_end;
    assign word_num = word_cnt_q + 16'd1;
    assign line_end = ((word_num % 16'(WORDS_PER_LINE)) == 16'd0) ||
                      (word_num == 16'(WORD_COUNT));
`endif

    dump_byte_serializer u_serializer (
        .clk_i       (clk_50m),
        .rst_ni      (reset_n),
        .load_i      (ser_load),
        .word_i      (rd_data),
`ifdef SDRAM_DUMP_HEX_ASCII_EN
        .crlf_i      (line_end),
`endif
        .advance_i   (ser_advance),
        .byte_o      (ser_byte),
        .last_byte_o (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        word_cnt_d  = word_cnt_q;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && sdram_init_done) begin
                    state_d    = StRdReq;
                    word_cnt_d = 16'd0;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
                wait_d  = 2'd0;
            end
            StRdWait: begin
                if (wait_q == 2'(RD_LATENCY - 1)) begin
                    ser_load = 1'b1;
                    state_d  = StCheck;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StCheck: begin
                if (!fifo_full) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ser_last) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    state_d    = StNext;
                end else begin
                    ser_advance = 1'b1;
                    state_d     = StCheck;
                end
            end
            StNext: begin
                state_d = (word_cnt_q == 16'(WORD_COUNT)) ? StDone : StRdReq;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so strobes line up with their states.
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wait_q     <= 2'd0;
            word_cnt_q <= 16'd0;
            rd_en_q    <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            word_cnt_q <= word_cnt_d;
            rd_en_q    <= (state_d == StRdReq);
            tx_req_q   <= (state_d == StSend);
            if (state_d == StSend) begin
                tx_data_q <= ser_byte;
            end
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
        end
    end

    assign rd_en        = rd_en_q;
    assign fifo_tx_req  = tx_req_q;
    assign fifo_tx_data = tx_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Scoreboard bench: one dump block at read latency 1, a second at read latency 3.
module tb_sdram_uart_dump;

`ifdef SDRAM_DUMP_HEX_ASCII_EN
    localparam int WC        = 9;
    localparam int EXP_BYTES = 47;
`else
    localparam int WC        = 4;
    localparam int EXP_BYTES = 8;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset_n, start, start3, init, full, full3;
    logic        rd_en, rd_en3, req, req3, busy, busy3, done, done3;
    logic [15:0] rd_data, rd_data3, word_cnt, word_cnt3;
    logic [7:0]  tx_data, tx_data3;

    sdram_uart_dump #(.WORD_COUNT(WC), .RD_LATENCY(1)) u_dut (
        .clk_50m(clk), .reset_n(reset_n), .start(start), .sdram_init_done(init),
        .rd_en(rd_en), .rd_data(rd_data), .fifo_tx_req(req), .fifo_tx_data(tx_data),
        .fifo_full(full), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    sdram_uart_dump #(.WORD_COUNT(WC), .RD_LATENCY(3)) u_dut3 (
        .clk_50m(clk), .reset_n(reset_n), .start(start3), .sdram_init_done(init),
        .rd_en(rd_en3), .rd_data(rd_data3), .fifo_tx_req(req3), .fifo_tx_data(tx_data3),
        .fifo_full(full3), .busy(busy3), .done(done3), .word_cnt(word_cnt3)
    );

    logic [15:0] vec [WC];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp3_q[$];
    int n_checks = 0, n_fail = 0;
    int rd_cnt = 0, rd3_cnt = 0, tx_cnt = 0, tx3_cnt = 0, done_cnt = 0, done3_cnt = 0;
    logic full_at_edge = 1'b0;

    // SDRAM read-FIFO model: data valid only RD_LATENCY cycles after rd_en, poison otherwise.
    logic        h1 = 1'b0;
    logic [2:0]  h3 = 3'b000;
    logic [15:0] cur = 16'h0, cur3 = 16'h0;
    int          pop = 0, pop3 = 0;

    always @(posedge clk) begin
        full_at_edge <= full;
        if (!reset_n) begin
            h1 <= 1'b0; h3 <= 3'b000; pop <= 0; pop3 <= 0;
        end else begin
            h1 <= rd_en;
            h3 <= {h3[1:0], rd_en3};
            if (rd_en) begin
                cur <= vec[pop];
                pop <= (pop == WC - 1) ? 0 : pop + 1;
            end
            if (rd_en3) begin
                cur3 <= vec[pop3];
                pop3 <= (pop3 == WC - 1) ? 0 : pop3 + 1;
            end
        end
    end

    assign rd_data  = h1    ? cur  : 16'hDEAD;
    assign rd_data3 = h3[2] ? cur3 : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string digits = "0123456789ABCDEF";
        return digits[int'(n)];
    endfunction

    function automatic void push_dump(input bit second);
        logic [7:0] b[$];
        for (int i = 0; i < WC; i++) begin
`ifdef SDRAM_DUMP_HEX_ASCII_EN
            for (int k = 0; k < 4; k++) b.push_back(hexc(vec[i][15 - 4 * k -: 4]));
            if (((i + 1) % 8 == 0) || (i == WC - 1)) begin
                b.push_back(8'h0D);
                b.push_back(8'h0A);
            end else begin
                b.push_back(8'h20);
            end
`else
            b.push_back(vec[i][15:8]);
            b.push_back(vec[i][7:0]);
`endif
        end
        foreach (b[j]) begin
            if (second) exp3_q.push_back(b[j]);
            else        exp_q.push_back(b[j]);
        end
    endfunction

    // Monitor: counts strobes and pops the scoreboard on every byte written.
    always @(negedge clk) begin
        if (rd_en)  rd_cnt++;
        if (rd_en3) rd3_cnt++;
        if (done)   done_cnt++;
        if (done3)  done3_cnt++;
        if (req) begin
            tx_cnt++;
            check("no_req_while_full", 32'(full_at_edge), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        if (req3) begin
            tx3_cnt++;
            if (exp3_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_byte_lat3: got %0h, expected no byte", tx_data3);
            end else begin
                check("tx_byte_lat3", 32'(tx_data3), 32'(exp3_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input bit second);
        tick();
        if (second) start3 = 1'b1;
        else        start  = 1'b1;
        tick();
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit second, input string name);
        int d0 = second ? done3_cnt : done_cnt;
        int k;
        for (k = 0; k < 3000; k++) begin
            tick();
            if ((second ? done3_cnt : done_cnt) != d0) break;
        end
        check(name, 32'(k < 3000), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_tx_req"}, 32'(req), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        int b_rd, b_tx, b_done, k;
`ifdef SDRAM_DUMP_HEX_ASCII_EN
        for (int i = 0; i < WC; i++) vec[i] = 16'h0A5F;
`else
        vec[0] = 16'h1234; vec[1] = 16'hABCD; vec[2] = 16'h0000; vec[3] = 16'hFFFF;
`endif
        reset_n = 1'b0; start = 1'b0; start3 = 1'b0; init = 1'b1; full = 1'b0; full3 = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Plain dump, no back-pressure.
        b_rd = rd_cnt; b_tx = tx_cnt; b_done = done_cnt;
        push_dump(1'b0);
        pulse_start(1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(1'b0, "dump_a_finishes");
        tick();
        check("dump_a_rd_en_count", 32'(rd_cnt - b_rd), 32'(WC));
        check("dump_a_byte_count", 32'(tx_cnt - b_tx), 32'(EXP_BYTES));
        check("dump_a_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("dump_a_word_cnt", 32'(word_cnt), 32'(WC));
        check("dump_a_busy_low", 32'(busy), 32'd0);
        check("dump_a_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure after the first byte.
        b_tx = tx_cnt;
        push_dump(1'b0);
        pulse_start(1'b0);
        for (k = 0; k < 100 && tx_cnt == b_tx; k++) tick();
        full = 1'b1;
        repeat (20) tick();
        check("bp_no_bytes_while_full", 32'(tx_cnt - b_tx), 32'd1);
        full = 1'b0;
        for (k = 0; k < 2 && tx_cnt == b_tx + 1; k++) begin
            @(negedge clk);
            #1;
        end
        check("bp_resume_within_2", 32'(tx_cnt - b_tx), 32'd2);
        wait_done(1'b0, "bp_dump_finishes");
        tick();
        check("bp_byte_count", 32'(tx_cnt - b_tx), 32'(EXP_BYTES));
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Start without init is dropped; start while busy is ignored.
        b_rd = rd_cnt;
        init = 1'b0;
        pulse_start(1'b0);
        init = 1'b1;
        repeat (10) tick();
        check("noinit_busy_low", 32'(busy), 32'd0);
        check("noinit_no_rd_en", 32'(rd_cnt - b_rd), 32'd0);
        b_done = done_cnt;
        push_dump(1'b0);
        pulse_start(1'b0);
        check("word_cnt_cleared_on_start", 32'(word_cnt), 32'd0);
        repeat (3) tick();
        pulse_start(1'b0);
        wait_done(1'b0, "busy_start_dump_finishes");
        tick();
        check("busy_start_rd_en_count", 32'(rd_cnt - b_rd), 32'(WC));
        check("busy_start_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset the cycle after the third rd_en.
        b_rd = rd_cnt;
        push_dump(1'b0);
        pulse_start(1'b0);
        for (k = 0; k < 500 && rd_cnt != b_rd + 3; k++) tick();
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (3) tick();
        check("midreset_no_rd_en", 32'(rd_cnt - b_rd), 32'd3);
        reset_n = 1'b1;
        tick();
        push_dump(1'b0);
        pulse_start(1'b0);
        wait_done(1'b0, "post_reset_dump_finishes");
        tick();
        check("post_reset_word_cnt", 32'(word_cnt), 32'(WC));
        check("post_reset_rd_en_count", 32'(rd_cnt - b_rd), 32'(3 + WC));
        check("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);

        // Read latency 3: data is valid only on the sampling cycle.
        push_dump(1'b1);
        pulse_start(1'b1);
        wait_done(1'b1, "lat3_dump_finishes");
        tick();
        check("lat3_rd_en_count", 32'(rd3_cnt), 32'(WC));
        check("lat3_byte_count", 32'(tx3_cnt), 32'(EXP_BYTES));
        check("lat3_word_cnt", 32'(word_cnt3), 32'(WC));
        check("lat3_queue_empty", 32'(exp3_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
